alarm_scheduler: RTL and testbench

- Time-of-day and alarm sequencer that generates the `alarm` request level consumed by the bedroom alarm FSM.
- Keeps a 24 h hh:mm clock advanced by a one-cycle minute tick, holds a programmed alarm time, and starts ringing on match.
- Manages snooze and dismiss, a bounded snooze count and a ring timeout.
- Optional weekday-only gating.

---
 rtl/alarm_scheduler.sv | 150 +++++++++++++++
 tb/tb_alarm_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// Time-of-day clock with one programmable alarm, snooze/dismiss handling,
// a bounded snooze count, a ring timeout and optional weekday-only gating.
module alarm_scheduler #(
  parameter int SNOOZE_MIN   = 9,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       time_set,
  input  logic       alarm_set,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       arm,
  input  logic       weekday_only,
  input  logic       weekday,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm,
  output logic       snoozing,
  output logic       missed,
  output logic [2:0] snooze_cnt,
  output logic [4:0] cur_hour,
  output logic [5:0] cur_min
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZING} state_t;

  localparam logic [5:0] SNOOZE_LOAD = 6'(SNOOZE_MIN);
  localparam logic [5:0] RING_LAST   = 6'(RING_TIMEOUT - 1);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_t     state;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic [5:0] ring_timer;
  logic [5:0] snooze_timer;

  logic [4:0] set_hour_c, inc_hour;
  logic [5:0] set_min_c, inc_min;
  logic       match;

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    set_hour_c = (set_hour > 5'd23) ? 5'd0 : set_hour;
    set_min_c  = (set_min > 6'd59) ? 6'd0 : set_min;
    inc_min    = cur_min + 6'd1;
    inc_hour   = cur_hour;
    if (cur_min == 6'd59) begin
      inc_min  = 6'd0;
      inc_hour = (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
    end
    // Match looks at the time the clock is about to show after this tick.
    match = tick && !time_set && !alarm_set && (state == IDLE) && arm &&
            (!weekday_only || weekday) &&
            (inc_hour == al_hour) && (inc_min == al_min);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      alarm        <= 1'b0;
      snoozing     <= 1'b0;
      missed       <= 1'b0;
      snooze_cnt   <= '0;
      cur_hour     <= '0;
      cur_min      <= '0;
      al_hour      <= '0;
      al_min       <= '0;
      ring_timer   <= '0;
      snooze_timer <= '0;
    end else begin
      if (time_set) begin
        cur_hour <= set_hour_c;
        cur_min  <= set_min_c;
      end else if (tick) begin
        cur_hour <= inc_hour;
        cur_min  <= inc_min;
      end

      if (alarm_set) begin
        al_hour <= set_hour_c;
        al_min  <= set_min_c;
        missed  <= 1'b0;
        if (state != IDLE) begin
          state      <= IDLE;
          alarm      <= 1'b0;
          snoozing   <= 1'b0;
          snooze_cnt <= '0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (match) begin
              state      <= RINGING;
              alarm      <= 1'b1;
              snooze_cnt <= '0;
              ring_timer <= '0;
            end
          end
          RINGING: begin
            if (stop) begin
              state  <= IDLE;
              alarm  <= 1'b0;
              missed <= 1'b0;
            end else if (snooze && (snooze_cnt < SNOOZE_MAX)) begin
              state        <= SNOOZING;
              alarm        <= 1'b0;
              snoozing     <= 1'b1;
              snooze_cnt   <= snooze_cnt + 3'd1;
              snooze_timer <= SNOOZE_LOAD;
            end else if (tick) begin
              if (ring_timer == RING_LAST) begin
                state  <= IDLE;
                alarm  <= 1'b0;
                missed <= 1'b1;
              end else begin
                ring_timer <= ring_timer + 6'd1;
              end
            end
          end
          SNOOZING: begin
            if (stop) begin
              state    <= IDLE;
              snoozing <= 1'b0;
              missed   <= 1'b0;
            end else if (tick) begin
              if (snooze_timer == 6'd1) begin
                state      <= RINGING;
                alarm      <= 1'b1;
                snoozing   <= 1'b0;
                ring_timer <= '0;
              end else begin
                snooze_timer <= snooze_timer - 6'd1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            alarm    <= 1'b0;
            snoozing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with hand-computed expectations and
// immediate assertions at each comparison point.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, time_set, alarm_set;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       arm, weekday_only, weekday, snooze, stop;
  logic       alarm, snoozing, missed;
  logic [2:0] snooze_cnt;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;

  int n_cmp = 0;
  int n_err = 0;

  alarm_scheduler #(.SNOOZE_MIN(9), .MAX_SNOOZE(3), .RING_TIMEOUT(30)) dut (
    .clk(clk), .rst(rst), .tick(tick), .time_set(time_set), .alarm_set(alarm_set),
    .set_hour(set_hour), .set_min(set_min), .arm(arm), .weekday_only(weekday_only),
    .weekday(weekday), .snooze(snooze), .stop(stop), .alarm(alarm),
    .snoozing(snoozing), .missed(missed), .snooze_cnt(snooze_cnt),
    .cur_hour(cur_hour), .cur_min(cur_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks alarm, snoozing, missed, snooze_cnt and hh:mm in one call.
  task automatic check_all(input string tag, input logic a, input logic s, input logic m,
                           input logic [2:0] c, input logic [4:0] h, input logic [5:0] mi);
    check({tag, ".alarm"}, 32'(alarm), 32'(a));
    check({tag, ".snoozing"}, 32'(snoozing), 32'(s));
    check({tag, ".missed"}, 32'(missed), 32'(m));
    check({tag, ".snooze_cnt"}, 32'(snooze_cnt), 32'(c));
    check({tag, ".hhmm"}, 32'({cur_hour, cur_min}), 32'({h, mi}));
  endtask

  // Called at a negedge: holds the strobes for one full cycle, returns at the next negedge.
  task automatic pulse(input logic t, input logic ts, input logic as, input logic sn, input logic st);
    tick = t; time_set = ts; alarm_set = as; snooze = sn; stop = st;
    @(negedge clk);
    tick = 1'b0; time_set = 1'b0; alarm_set = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m);
    set_hour = h; set_min = m;
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tick = 0; time_set = 0; alarm_set = 0; snooze = 0; stop = 0;
    set_hour = 0; set_min = 0; arm = 0; weekday_only = 0; weekday = 0;
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Program 06:59 / alarm 07:00 and ring on the first tick.
    set_time(5'd6, 6'd59);
    check("time_set", 32'({cur_hour, cur_min}), 32'({5'd6, 6'd59}));
    set_hour = 5'd7; set_min = 6'd0;
    pulse(0, 0, 1, 0, 0);
    arm = 1'b1;
    ticks(1);
    check_all("match", 1, 0, 0, 0, 7, 0);
    pulse(0, 0, 0, 0, 1);
    check_all("stop", 0, 0, 0, 0, 7, 0);

    // Snooze cycle: 8 ticks still snoozing, 9th re-rings at 07:09.
    set_time(5'd6, 6'd59);
    ticks(1);
    pulse(0, 0, 0, 1, 0);
    check_all("snooze1", 0, 1, 0, 1, 7, 0);
    ticks(8);
    check_all("snooze_8", 0, 1, 0, 1, 7, 8);
    ticks(1);
    check_all("resnooze_ring", 1, 0, 0, 1, 7, 9);
    pulse(0, 0, 0, 1, 0);
    ticks(9);
    check_all("ring_0718", 1, 0, 0, 2, 7, 18);
    pulse(0, 0, 0, 1, 0);
    ticks(9);
    check_all("ring_0727", 1, 0, 0, 3, 7, 27);
    pulse(0, 0, 0, 1, 0);
    check_all("snooze_ignored", 1, 0, 0, 3, 7, 27);
    pulse(0, 0, 0, 0, 1);
    check_all("cnt_held_idle", 0, 0, 0, 3, 7, 27);

    // Unattended ringing times out after 30 ticks.
    set_time(5'd6, 6'd59);
    ticks(1);
    check_all("ring_again", 1, 0, 0, 0, 7, 0);
    ticks(29);
    check_all("ring_0729", 1, 0, 0, 0, 7, 29);
    ticks(1);
    check_all("timeout", 0, 0, 1, 0, 7, 30);
    set_time(5'd6, 6'd59);
    ticks(1);
    check_all("next_day", 1, 0, 1, 0, 7, 0);
    pulse(0, 0, 0, 0, 1);
    check_all("stop_clears_missed", 0, 0, 0, 0, 7, 0);

    // Weekday gating.
    weekday_only = 1'b1; weekday = 1'b0;
    set_time(5'd6, 6'd59);
    ticks(1);
    check_all("weekend_blocked", 0, 0, 0, 0, 7, 0);
    weekday = 1'b1;
    set_time(5'd6, 6'd59);
    ticks(1);
    check("weekday_rings", 32'(alarm), 32'd1);
    pulse(0, 0, 0, 0, 1);
    weekday_only = 1'b0;

    // Midnight wrap.
    set_time(5'd23, 6'd59);
    ticks(1);
    check_all("wrap", 0, 0, 0, 0, 0, 0);

    // Stop on the expiring snooze minute wins.
    set_time(5'd6, 6'd59);
    ticks(1);
    pulse(0, 0, 0, 1, 0);
    ticks(8);
    pulse(1, 0, 0, 0, 1);
    check_all("stop_beats_tick", 0, 0, 0, 1, 7, 9);
    ticks(1);
    check_all("no_late_ring", 0, 0, 0, 1, 7, 10);

    // time_set with tick: load, no advance; out-of-range values load zero.
    set_hour = 5'd12; set_min = 6'd34;
    pulse(1, 1, 0, 0, 0);
    check("time_set_over_tick", 32'({cur_hour, cur_min}), 32'({5'd12, 6'd34}));
    set_time(5'd25, 6'd61);
    check("clamp", 32'({cur_hour, cur_min}), 32'd0);

    // alarm_set while ringing forces IDLE.
    set_time(5'd6, 6'd59);
    ticks(1);
    set_hour = 5'd8; set_min = 6'd0;
    pulse(0, 0, 1, 0, 0);
    check_all("alarm_set_idle", 0, 0, 0, 0, 7, 0);

    // arm=0 suppresses a match.
    arm = 1'b0;
    set_time(5'd7, 6'd59);
    ticks(1);
    check_all("disarmed", 0, 0, 0, 0, 8, 0);

    // Async reset while ringing.
    arm = 1'b1;
    set_time(5'd7, 6'd59);
    ticks(1);
    check("ring_before_rst", 32'(alarm), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
